// File: rtl/complex_div.sv
// rtl/complex_div.sv - sequential fixed-point complex divider (A/B)
//
// Purpose: computes A/B = ((Ar*Br + Ai*Bi) + j(Ai*Br - Ar*Bi)) / (Br^2 + Bi^2)
// on signed fixed-point operands. One restoring-division datapath is shared:
// first it produces the real quotient, then the imaginary quotient, one bit per cycle.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   i_start      request an operation (sampled only while idle)
//   inAr, inAi   dividend real/imag, signed p_inputWidth bits
//   inBr, inBi   divisor real/imag, signed p_inputWidth bits
//   o_busy       high from PREP through DONE
//   o_valid      one-cycle pulse marking a new result
//   o_QR, o_QI   signed quotient, M+1 bits, p_PointPosition fractional bits
//   o_divByZero  divisor was 0+j0 (quotient forced to 0)
module complex_div #(
  parameter int p_inputWidth    = 8,
  parameter int p_PointPosition = 3,
  localparam int M              = 2*p_inputWidth + p_PointPosition
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_start,
  input  logic signed [p_inputWidth-1:0] inAr,
  input  logic signed [p_inputWidth-1:0] inAi,
  input  logic signed [p_inputWidth-1:0] inBr,
  input  logic signed [p_inputWidth-1:0] inBi,
  output logic                        o_busy,
  output logic                        o_valid,
  output logic signed [M:0]           o_QR,
  output logic signed [M:0]           o_QI,
  output logic                        o_divByZero
);

  localparam int W  = p_inputWidth;
  localparam int P  = p_PointPosition;
  localparam int CW = $clog2(M);

  typedef enum logic [2:0] {IDLE, PREP, DIV_R, DIV_I, DONE} state_t;

  state_t r_state, w_next;

  logic signed [W-1:0] r_ar, r_ai, r_br, r_bi;
  logic [2*W-1:0]      r_d;       // divisor magnitude Br^2+Bi^2
  logic [2*W-1:0]      r_rem;     // partial remainder, always < r_d
  logic [M-1:0]        r_dvd;     // dividend bits shift out the top, quotient bits shift in the bottom
  logic [CW-1:0]       r_cnt;
  logic                r_neg;     // sign of the numerator currently being divided
  logic [M-1:0]        r_ni_dvd;  // imaginary dividend parked while the real part runs
  logic                r_ni_neg;
  logic signed [M:0]   r_qr;      // real result parked until both parts are done

  // Operands sign-extended to the full numerator width so products never truncate.
  logic signed [2*W:0] w_ar_x, w_ai_x, w_br_x, w_bi_x;
  logic signed [2*W:0] w_nr, w_ni;
  logic [W-1:0]        w_br_abs, w_bi_abs;
  logic [2*W-1:0]      w_d;
  logic [2*W:0]        w_rem_sh, w_rem_sub;
  logic                w_ge, w_last;
  logic [2*W-1:0]      w_rem_nxt;
  logic [M-1:0]        w_dq_nxt;
  logic signed [M:0]   w_q_signed;

  function automatic logic [M-1:0] f_dvd(input logic signed [2*W:0] n);
    logic [2*W:0] mag;
    mag = n[2*W] ? -n : n;
    // |N| never exceeds 2^(2W-1), so dropping the top bit after the shift loses nothing.
    return M'({mag, {P{1'b0}}});
  endfunction

  function automatic logic signed [M:0] f_apply_sign(input logic [M-1:0] q, input logic neg);
    logic signed [M:0] s;
    s = $signed({1'b0, q});
    return neg ? -s : s;
  endfunction

  assign w_ar_x = {{(W+1){r_ar[W-1]}}, r_ar};
  assign w_ai_x = {{(W+1){r_ai[W-1]}}, r_ai};
  assign w_br_x = {{(W+1){r_br[W-1]}}, r_br};
  assign w_bi_x = {{(W+1){r_bi[W-1]}}, r_bi};
  assign w_nr   = w_ar_x * w_br_x + w_ai_x * w_bi_x;
  assign w_ni   = w_ai_x * w_br_x - w_ar_x * w_bi_x;

  // Squares taken on magnitudes: |B|^2 <= 2^(2W-1) fits 2W unsigned bits.
  assign w_br_abs = r_br[W-1] ? W'(-r_br) : W'(r_br);
  assign w_bi_abs = r_bi[W-1] ? W'(-r_bi) : W'(r_bi);
  assign w_d      = {{W{1'b0}}, w_br_abs} * {{W{1'b0}}, w_br_abs}
                  + {{W{1'b0}}, w_bi_abs} * {{W{1'b0}}, w_bi_abs};

  // One restoring-division step.
  assign w_rem_sh   = {r_rem, r_dvd[M-1]};
  assign w_rem_sub  = w_rem_sh - {1'b0, r_d};
  assign w_ge       = (w_rem_sh >= {1'b0, r_d});
  assign w_rem_nxt  = w_ge ? (2*W)'(w_rem_sub) : (2*W)'(w_rem_sh);
  assign w_dq_nxt   = {r_dvd[M-2:0], w_ge};
  assign w_last     = (r_cnt == CW'(M-1));
  assign w_q_signed = f_apply_sign(w_dq_nxt, r_neg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    o_busy  = 1'b1;
    o_valid = 1'b0;
    case (r_state)
      IDLE: begin
        o_busy = 1'b0;
        if (i_start) w_next = PREP;
      end
      PREP:    w_next = (w_d == '0) ? DONE : DIV_R;
      DIV_R:   if (w_last) w_next = DIV_I;
      DIV_I:   if (w_last) w_next = DONE;
      DONE: begin
        o_valid = 1'b1;
        w_next  = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ar <= '0; r_ai <= '0; r_br <= '0; r_bi <= '0;
      r_d <= '0; r_rem <= '0; r_dvd <= '0; r_cnt <= '0; r_neg <= 1'b0;
      r_ni_dvd <= '0; r_ni_neg <= 1'b0; r_qr <= '0;
      o_QR <= '0; o_QI <= '0; o_divByZero <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (i_start) begin
          r_ar <= inAr; r_ai <= inAi; r_br <= inBr; r_bi <= inBi;
        end
        PREP: begin
          r_d      <= w_d;
          r_rem    <= '0;
          r_dvd    <= f_dvd(w_nr);
          r_neg    <= w_nr[2*W];
          r_ni_dvd <= f_dvd(w_ni);
          r_ni_neg <= w_ni[2*W];
          r_cnt    <= '0;
          if (w_d == '0) begin
            o_QR <= '0; o_QI <= '0; o_divByZero <= 1'b1;
          end
        end
        DIV_R: begin
          r_rem <= w_rem_nxt;
          r_dvd <= w_dq_nxt;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            // Real quotient complete: park it and reload the divider with the imaginary numerator.
            r_qr  <= w_q_signed;
            r_rem <= '0;
            r_dvd <= r_ni_dvd;
            r_neg <= r_ni_neg;
            r_cnt <= '0;
          end
        end
        DIV_I: begin
          r_rem <= w_rem_nxt;
          r_dvd <= w_dq_nxt;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            o_QR <= r_qr; o_QI <= w_q_signed; o_divByZero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_complex_div.sv
// tb/tb_complex_div.sv - scoreboard testbench for complex_div
module tb_complex_div;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic i_start = 1'b0;
  logic signed [7:0] inAr = '0, inAi = '0, inBr = '0, inBi = '0;
  logic o_busy, o_valid, o_divByZero;
  logic signed [19:0] o_QR, o_QI;

  complex_div dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start),
    .inAr(inAr), .inAi(inAi), .inBr(inBr), .inBi(inBi),
    .o_busy(o_busy), .o_valid(o_valid),
    .o_QR(o_QR), .o_QI(o_QI), .o_divByZero(o_divByZero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic signed [19:0] qr;
    logic signed [19:0] qi;
    logic               dbz;
    int                 edge_n;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int n_valid = 0;

  task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, act, want);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: compare every result pulse against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && o_valid) begin
        n_valid++;
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_valid got qr=%0d want no pulse", o_QR);
        end else begin
          e = sb.pop_front();
          check("qr", o_QR, e.qr);
          check("qi", o_QI, e.qi);
          check("dbz", {31'd0, o_divByZero}, {31'd0, e.dbz});
          check("latency_edge", cyc, e.edge_n);
        end
      end
    end
  end

  // Start edge is the next posedge (index cyc+1); o_valid is seen after edge +39 or +1.
  task automatic start_op(input int ar, input int ai, input int br, input int bi,
                          input bit push, input int eqr, input int eqi, input bit edbz);
    exp_t e;
    @(negedge clk);
    inAr = 8'(ar); inAi = 8'(ai); inBr = 8'(br); inBi = 8'(bi);
    i_start = 1'b1;
    if (push) begin
      e.qr = 20'(eqr); e.qi = 20'(eqi); e.dbz = edbz;
      e.edge_n = cyc + 1 + (edbz ? 1 : 39);
      sb.push_back(e);
    end
    @(negedge clk);
    i_start = 1'b0;
    inAr = 8'sd99; inAi = -8'sd77; inBr = 8'sd5; inBi = 8'sd3;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout got pending=%0d want 0", sb.size());
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int nv0;
    #100000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1);
  end

  initial begin
    int nv0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, o_busy}, 0);
    check("rst_valid", {31'd0, o_valid}, 0);
    check("rst_qr", o_QR, 0);
    check("rst_qi", o_QI, 0);
    check("rst_dbz", {31'd0, o_divByZero}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vectors, raw fixed-point integers (8 = 1.0)
    start_op(16, 16, 8, 8, 1, 16, 0, 0);          drain();
    start_op(8, 0, 0, 8, 1, 0, -8, 0);            drain();
    start_op(8, 0, 24, 0, 1, 2, 0, 0);            drain();
    start_op(-8, 0, 24, 0, 1, -2, 0, 0);          drain();
    start_op(40, -16, 0, 0, 1, 0, 0, 1);          drain();
    start_op(8, 0, 8, 0, 1, 8, 0, 0);             drain();
    start_op(24, 8, 8, -8, 1, 8, 16, 0);          drain();
    start_op(127, 127, 1, 0, 1, 1016, 1016, 0);   drain();
    start_op(-128, -128, 0, 1, 1, -1024, 1024, 0); drain();
    start_op(-128, -128, -128, -128, 1, 8, 0, 0); drain();
    start_op(0, 0, 3, 5, 1, 0, 0, 0);             drain();

    // New start during DIV_R must be ignored
    nv0 = n_valid;
    start_op(16, 16, 8, 8, 1, 16, 0, 0);
    repeat (10) @(negedge clk);
    check("busy_mid_div", {31'd0, o_busy}, 1);
    inAr = 8'sd8; inAi = 8'sd0; inBr = 8'sd0; inBi = 8'sd8;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    drain();
    repeat (45) @(negedge clk);
    check("ignored_start_pulses", n_valid - nv0, 1);

    // Reset during DIV_I aborts with no pulse
    nv0 = n_valid;
    start_op(8, 0, 8, 0, 0, 0, 0, 0);
    repeat (29) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_qr", o_QR, 0);
    check("abort_qi", o_QI, 0);
    check("abort_busy", {31'd0, o_busy}, 0);
    check("abort_valid", {31'd0, o_valid}, 0);
    check("abort_dbz", {31'd0, o_divByZero}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    check("abort_no_pulse", n_valid - nv0, 0);
    start_op(24, 8, 8, -8, 1, 8, 16, 0);          drain();

    check("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/complex_div.md
COMPLEX_DIV -- requirements
Module: complex_div

Interface
REQ-001 The block SHALL have parameter p_inputWidth, default 8, the signed operand width in bits.
REQ-002 The block SHALL have parameter p_PointPosition, default 3, the fractional bits of operands and results.
REQ-003 The block SHALL define derived constant M = 2*p_inputWidth + p_PointPosition, the magnitude-quotient bits (19 at defaults).
REQ-004 Port clk  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-005 Port rst_n  input  1  SHALL be an asynchronous, active-low reset.
REQ-006 Port i_start  input  1  requests an operation.
REQ-007 Ports inAr, inAi  input  p_inputWidth, signed  are the dividend real and imaginary parts.
REQ-008 Ports inBr, inBi  input  p_inputWidth, signed  are the divisor real and imaginary parts.
REQ-009 Port o_busy  output  1  SHALL be high while an operation is in progress.
REQ-010 Port o_valid  output  1  SHALL be a one-cycle pulse marking a new result.
REQ-011 Ports o_QR, o_QI  output  M+1, signed  SHALL carry the quotient with p_PointPosition fractional bits.
REQ-012 Port o_divByZero  output  1  SHALL flag that the divisor was 0+j0.

Function
REQ-013 The block SHALL compute (A)/(B) = ((Ar*Br + Ai*Bi) + j(Ai*Br - Ar*Bi)) / (Br^2 + Bi^2).
REQ-014 The FSM SHALL have states IDLE, PREP, DIV_R, DIV_I, DONE.
REQ-015 In IDLE, the edge that samples i_start=1 SHALL register inAr..inBi and enter PREP; inputs SHALL be ignored at all other times.
REQ-016 PREP SHALL form Nr and Ni at full 2*p_inputWidth+1 signed width and D = Br^2+Bi^2 at 2*p_inputWidth unsigned width, all without truncation.
REQ-017 If D != 0, PREP SHALL go to DIV_R; if D == 0, PREP SHALL go directly to DONE with o_QR=0, o_QI=0, o_divByZero=1.
REQ-018 DIV_R and DIV_I SHALL each run an M-iteration restoring division at one quotient bit per cycle, using a shared divider datapath that computes (|N| << p_PointPosition) / D.
REQ-019 Each quotient SHALL truncate toward zero, then take the sign of its numerator; a zero numerator SHALL give +0.
REQ-020 After M cycles DIV_R SHALL go to DIV_I; after M cycles DIV_I SHALL go to DONE and load o_QR, o_QI, and o_divByZero=0.
REQ-021 DONE SHALL assert o_valid for exactly one cycle, then return to IDLE.
REQ-022 Latency SHALL be as follows, where edge k samples i_start: with D != 0, o_valid is high in the cycle after edge k+2M+1 (edge k+39 at defaults); with D == 0, o_valid is high in the cycle after edge k+1.
REQ-023 o_busy SHALL be high in PREP, DIV_R, DIV_I and DONE, and low in IDLE.
REQ-024 i_start while o_busy=1 SHALL be ignored, with no effect on the running operation.
REQ-025 o_QR, o_QI and o_divByZero SHALL be registered and SHALL hold their values until the next DONE.
REQ-026 M+1 output bits SHALL hold every result without overflow, so no saturation logic is required.

Reset
REQ-027 When rst_n=0, the block SHALL immediately enter IDLE and clear o_busy, o_valid, o_QR, o_QI, o_divByZero and all internal registers to 0.
REQ-028 Reset asserted mid-operation SHALL abort the operation with no o_valid pulse.
REQ-029 After rst_n deasserts, the first i_start SHALL start a fresh operation.

Verification (defaults W=8, P=3; values are raw integers, 8 = 1.0)
REQ-030 Start with A=(16,16), B=(8,8) -> o_valid 39 edges after the start edge, o_QR=16, o_QI=0, o_divByZero=0.
REQ-031 Start with A=(8,0), B=(0,8) -> o_QR=0, o_QI=-8.
REQ-032 Start with A=(8,0), B=(24,0), then A=(-8,0), B=(24,0) -> o_QR=2, then o_QR=-2 (truncation toward zero).
REQ-033 Start with A=(40,-16), B=(0,0) -> o_valid one edge after PREP, o_divByZero=1, o_QR=0, o_QI=0; a following A=(8,0), B=(8,0) start -> o_QR=8, o_divByZero=0.
REQ-034 Pulse i_start with new operands mid-DIV_R -> ignored, result matches the first operands, exactly one o_valid.
REQ-035 Assert rst_n=0 during DIV_I -> all outputs 0 asynchronously, no o_valid pulse; a new start after release -> correct result at full latency.
